cnt_ctrl_frontend: RTL and testbench
====================================

# cnt_ctrl_frontend

Control front-end that sits directly upstream of the 4-bit up/down counter and drives its SS, MODE and reset inputs from three raw push-buttons. Each button is synchronised and debounced. Debounced presses toggle run/stop and up/down, or issue a counter clear. A prescaler turns the run state into a one-cycle SS step pulse every TICK_DIV clocks, so the counter advances at a controlled rate on the shared clock.

## Interface
Parameters:
- DB_CYCLES, 16, consecutive cycles a synchronised button level must differ from the debounced level before it is accepted; legal range ≥1.
- TICK_DIV, 8, clocks per counter step while running; legal range ≥1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- BTN_SS  input  1  raw, asynchronous start/stop button, high = pressed.
- BTN_MODE  input  1  raw, asynchronous up/down button, high = pressed.
- BTN_CLR  input  1  raw, asynchronous clear button, high = pressed.
- SS  output  1  one-cycle step pulse to the counter's SS input.
- MODE  output  1  counting direction to the counter: 1 = up, 0 = down.
- CNT_RST  output  1  active-high reset pulse to the counter.
- RUN  output  1  run/stop status, 1 = running.

## Operation
- All outputs are registered.
- While rst=0, outputs are asynchronously forced to SS=0, MODE=1, RUN=0 and CNT_RST=1. All internal synchroniser, debounce and prescaler state is cleared to 0.
- On the first rising edge after rst returns to 1, CNT_RST drops to 0. This gives the counter one reset-active edge after system reset.
- Per button, synchronisation: a 2-flop chain, s1 then s2.
- Per button, debounce: a debounced level `db` and a counter `dc` of width $clog2(DB_CYCLES+1).
  - If s2==db, dc is set to 0.
  - Otherwise, if dc==DB_CYCLES-1, db is set to s2 and dc to 0.
  - Otherwise dc increments.
- A press event is the edge on which db changes 0→1; its action is applied on that same edge. Releases (db 1→0) have no action.
- An SS press toggles RUN.
- A MODE press toggles MODE.
- A CLR press sets CNT_RST=1 for exactly one cycle and forces RUN=0. CNT_RST is otherwise 0.
- Prescaler `pc` counts 0..TICK_DIV-1 and is evaluated using the RUN value from before the current edge.
  - While RUN=1: if pc==TICK_DIV-1, then SS is set to 1 and pc to 0; otherwise pc increments and SS is set to 0.
  - While RUN=0: pc is set to 0 and SS to 0.
- Stop wins over a step: on any edge where RUN is being cleared (SS press while running, or CLR), SS is set to 0 and pc to 0.
- Simultaneous events on the same edge:
  - CLR together with an SS press: CLR wins, so RUN=0 and the SS press is discarded.
  - CLR together with a MODE press: MODE toggles and CNT_RST=1. The counter therefore samples the new MODE together with its reset, and loads MIN for up or MAX for down.
  - SS press together with a MODE press: both apply.
- Holding a button produces exactly one event. Bounce shorter than DB_CYCLES cycles produces none.

## Timing
- Raw input rising before edge 1 reaches s2 at edge 2.
- db rises, and the corresponding action is applied, at edge 2+DB_CYCLES, provided s2 stays high throughout.
- Any glitch on s2 restarts the debounce count.
- Let RUN rise at edge E. SS is then high during the cycle after edge E+TICK_DIV, and again every TICK_DIV cycles after that. Each SS pulse is exactly 1 cycle wide.
- TICK_DIV=1: SS is continuously high from the cycle after edge E+1 until RUN is cleared.
- RUN falling at edge F gives SS=0 from edge F onward.
- Stop then restart restarts the prescaler phase: the first SS comes TICK_DIV edges after the restart.
- CNT_RST is high for the single cycle after the CLR press edge.
- Asserting rst mid-operation takes effect immediately. It aborts any pending debounce, so a button held across reset release produces one fresh press after 2+DB_CYCLES edges.

## Test plan
Bench parameters: DB_CYCLES=4, TICK_DIV=3.
- Reset release: during rst=0 expect SS=0, MODE=1, RUN=0, CNT_RST=1. Expect CNT_RST=0 after the first edge following release.
- Bounce: BTN_SS toggles every 2 cycles for 20 cycles, then stays at 0 → RUN stays 0.
- Clean SS press held for 10 cycles: RUN=1 at edge 6 after the rise. SS pulses in cycles after edges 9, 12 and 15. Holding the button gives no further toggle.
- Stop: a second SS press lands on the same edge the prescaler reaches 2 → RUN=0 and no SS pulse that cycle. Restart gives the first SS 3 edges after RUN rises.
- MODE press while running → MODE toggles 1→0; SS pulse cadence is unchanged.
- CLR and MODE debounced on the same edge while running → RUN=0, MODE toggles, CNT_RST high for exactly one cycle, and SS is never asserted afterwards.

Source files
------------

// File: rtl/cnt_ctrl_frontend.sv
// Button front-end for the up/down counter: synchronise, debounce and
// turn presses into run/stop, direction, clear and paced step pulses.
module cnt_ctrl_frontend #(
   parameter int DB_CYCLES = 16,
   parameter int TICK_DIV  = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic BTN_SS,
   input  logic BTN_MODE,
   input  logic BTN_CLR,
   output logic SS,
   output logic MODE,
   output logic CNT_RST,
   output logic RUN
);

   localparam int DCW = $clog2(DB_CYCLES + 1);
   localparam int PCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DCW-1:0] DC_LAST = DCW'(DB_CYCLES - 1);
   localparam logic [PCW-1:0] PC_LAST = PCW'(TICK_DIV - 1);

   // bit 0 = start/stop, bit 1 = mode, bit 2 = clear
   logic [2:0] s1_q, s1_d;
   logic [2:0] s2_q, s2_d;
   logic [2:0] db_q, db_d;
   logic [DCW-1:0] dc_q [3];
   logic [DCW-1:0] dc_d [3];
   logic [2:0] press;

   logic [PCW-1:0] pc_q, pc_d;
   logic ss_q, ss_d;
   logic mode_q, mode_d;
   logic run_q, run_d;
   logic cnt_rst_q, cnt_rst_d;

   always_comb begin
      s1_d = {BTN_CLR, BTN_MODE, BTN_SS};
      s2_d = s1_q;
      for (int i = 0; i < 3; i++) begin
         db_d[i] = db_q[i];
         dc_d[i] = dc_q[i] + 1'b1;
         if (s2_q[i] == db_q[i]) begin
            dc_d[i] = '0;
         end else if (dc_q[i] == DC_LAST) begin
            db_d[i] = s2_q[i];
            dc_d[i] = '0;
         end
      end
      press = db_d & ~db_q;
   end

   // Clear overrides a start/stop press; a stopping edge never steps.
   always_comb begin
      run_d = run_q;
      if (press[0]) run_d = ~run_q;
      if (press[2]) run_d = 1'b0;
      mode_d    = mode_q ^ press[1];
      cnt_rst_d = press[2];
      ss_d = 1'b0;
      pc_d = '0;
      if (run_q && run_d) begin
         if (pc_q == PC_LAST) ss_d = 1'b1;
         else                 pc_d = pc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         db_q      <= '0;
         dc_q      <= '{default: '0};
         pc_q      <= '0;
         ss_q      <= 1'b0;
         mode_q    <= 1'b1;
         run_q     <= 1'b0;
         cnt_rst_q <= 1'b1;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         db_q      <= db_d;
         dc_q      <= dc_d;
         pc_q      <= pc_d;
         ss_q      <= ss_d;
         mode_q    <= mode_d;
         run_q     <= run_d;
         cnt_rst_q <= cnt_rst_d;
      end
   end

   assign SS      = ss_q;
   assign MODE    = mode_q;
   assign CNT_RST = cnt_rst_q;
   assign RUN     = run_q;

endmodule

// File: tb/tb_cnt_ctrl_frontend.sv
// Directed bench for cnt_ctrl_frontend with DB_CYCLES=4, TICK_DIV=3.
// Edge numbers below count from the clean start/stop press.
module tb_cnt_ctrl_frontend;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_ss = 1'b0;
   logic btn_mode = 1'b0;
   logic btn_clr = 1'b0;
   logic ss, mode, cnt_rst, run;

   int checks = 0;
   int errors = 0;
   int e = 0;

   always #5 clk = ~clk;

   cnt_ctrl_frontend #(
      .DB_CYCLES(4),
      .TICK_DIV (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .BTN_SS  (btn_ss),
      .BTN_MODE(btn_mode),
      .BTN_CLR (btn_clr),
      .SS      (ss),
      .MODE    (mode),
      .CNT_RST (cnt_rst),
      .RUN     (run)
   );

   task automatic chk(input string tag, input int at, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s edge=%0d observed=%b expected=%b", tag, at, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      e++;
   endtask

   logic x_run, x_ss, x_mode, x_crst;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ss", 0, ss, 1'b0);
      chk("rst_mode", 0, mode, 1'b1);
      chk("rst_run", 0, run, 1'b0);
      chk("rst_cnt_rst", 0, cnt_rst, 1'b1);

      rst = 1'b1;
      tick();
      chk("rel_cnt_rst", 0, cnt_rst, 1'b0);
      chk("rel_run", 0, run, 1'b0);
      chk("rel_mode", 0, mode, 1'b1);

      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) btn_ss = ~btn_ss;
         tick();
         chk("bounce_run", i, run, 1'b0);
      end
      btn_ss = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("bounce_run", i, run, 1'b0);
         chk("bounce_ss", i, ss, 1'b0);
      end

      e = 0;
      btn_ss = 1'b1;
      while (e < 80) begin
         tick();
         x_run  = (e >= 6 && e < 24) || (e >= 39 && e < 66);
         x_ss   = (e >= 9 && e < 24 && (e - 6) % 3 == 0) ||
                  (e >= 42 && e < 66 && (e - 39) % 3 == 0);
         x_mode = (e >= 51 && e < 66) ? 1'b0 : 1'b1;
         x_crst = (e == 66);
         chk("run", e, run, x_run);
         chk("ss", e, ss, x_ss);
         chk("mode", e, mode, x_mode);
         chk("cnt_rst", e, cnt_rst, x_crst);
         case (e)
            10: btn_ss = 1'b0;
            18: btn_ss = 1'b1;
            26: btn_ss = 1'b0;
            33: btn_ss = 1'b1;
            40: btn_ss = 1'b0;
            45: btn_mode = 1'b1;
            52: btn_mode = 1'b0;
            60: begin
               btn_mode = 1'b1;
               btn_clr  = 1'b1;
            end
            68: begin
               btn_mode = 1'b0;
               btn_clr  = 1'b0;
            end
            default: ;
         endcase
      end

      btn_ss = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("async_cnt_rst", e, cnt_rst, 1'b1);
      chk("async_mode", e, mode, 1'b1);
      chk("async_run", e, run, 1'b0);
      #3;
      rst = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("post_rst_run", i, run, (i >= 6) ? 1'b1 : 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
